alu_exec_unit: RTL

- Next-generation execute stage for the MIPS datapath.
- Decodes the 3-bit ALUOp from main control and the 6-bit function field into a 4-bit ALU operation, executes single-cycle ops combinationally, and runs unsigned multiply/divide iteratively over DATA_WIDTH cycles into HI/LO registers.
- Drives a busy line so the pipeline can stall while a multiply/divide is in flight.

---
 rtl/alu_exec_unit_if.sv | 38 +++
 rtl/alu_exec_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// ============================================================================
// Module : alu_exec_unit_if
// Brief  : Operand/control/result bundle for the MIPS execute-stage ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_exec_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   start;
    logic [2:0]             alu_op;
    logic [5:0]             alu_function;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [DATA_WIDTH-1:0]  data_a;
    logic [DATA_WIDTH-1:0]  data_b;
    logic [3:0]             alu_operation;
    logic [DATA_WIDTH-1:0]  alu_result;
    logic                   zero;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  hi;
    logic [DATA_WIDTH-1:0]  lo;
    logic                   illegal;

    modport master (
        output start, alu_op, alu_function, shamt, data_a, data_b,
        input  alu_operation, alu_result, zero, busy, done, hi, lo, illegal
    );

    modport slave (
        input  start, alu_op, alu_function, shamt, data_a, data_b,
        output alu_operation, alu_result, zero, busy, done, hi, lo, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module : alu_exec_unit
// Brief  : ALU decode + single-cycle ops, iterative unsigned MULTU/DIVU to HI/LO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int COUNT_WIDTH = 6
) (
    input  logic          clk,
    input  logic          reset,
    alu_exec_unit_if.slave bus
);
    localparam int HALF = DATA_WIDTH / 2;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_NOR     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SRL     = 4'b0110;
    localparam logic [3:0] OP_LUI     = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_ILLEGAL = 4'b1001;
    localparam logic [3:0] OP_MFHI    = 4'b1010;
    localparam logic [3:0] OP_MFLO    = 4'b1011;
    localparam logic [3:0] OP_MULTU   = 4'b1100;
    localparam logic [3:0] OP_DIVU    = 4'b1101;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t                    state, state_next;
    logic [COUNT_WIDTH-1:0]    count;
    logic [DATA_WIDTH-1:0]     operand;
    logic [2*DATA_WIDTH-1:0]   partial;
    logic [DATA_WIDTH-1:0]     hi_reg, lo_reg;
    logic                      done_reg;

    logic [3:0]                operation;
    logic                      illegal;
    logic [DATA_WIDTH-1:0]     result;
    logic                      accept;
    logic                      last_step;
    logic [DATA_WIDTH:0]       mul_sum;
    logic [2*DATA_WIDTH-1:0]   mul_next;
    logic [DATA_WIDTH:0]       div_shift;
    logic [DATA_WIDTH:0]       div_trial;
    logic [2*DATA_WIDTH-1:0]   div_next;
    logic [2*DATA_WIDTH-1:0]   step_next;

    always_comb begin
        operation = OP_ILLEGAL;
        illegal   = 1'b1;
        case (bus.alu_op)
            3'b111: begin
                illegal = 1'b0;
                case (bus.alu_function)
                    6'b100100: operation = OP_AND;
                    6'b100101: operation = OP_OR;
                    6'b100111: operation = OP_NOR;
                    6'b100000: operation = OP_ADD;
                    6'b100010: operation = OP_SUB;
                    6'b000000: operation = OP_SLL;
                    6'b000010: operation = OP_SRL;
                    6'b101010: operation = OP_SLT;
                    6'b010000: operation = OP_MFHI;
                    6'b010010: operation = OP_MFLO;
                    6'b011001: operation = OP_MULTU;
                    6'b011011: operation = OP_DIVU;
                    default: begin
                        operation = OP_ILLEGAL;
                        illegal   = 1'b1;
                    end
                endcase
            end
            3'b100, 3'b010, 3'b011: begin operation = OP_ADD; illegal = 1'b0; end
            3'b101:                 begin operation = OP_OR;  illegal = 1'b0; end
            3'b110:                 begin operation = OP_AND; illegal = 1'b0; end
            3'b000:                 begin operation = OP_LUI; illegal = 1'b0; end
            3'b001:                 begin operation = OP_SUB; illegal = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        result = '0;
        case (operation)
            OP_ADD:  result = bus.data_a + bus.data_b;
            OP_SUB:  result = bus.data_a - bus.data_b;
            OP_AND:  result = bus.data_a & bus.data_b;
            OP_OR:   result = bus.data_a | bus.data_b;
            OP_NOR:  result = ~(bus.data_a | bus.data_b);
            OP_SLL:  result = bus.data_b << bus.shamt;
            OP_SRL:  result = bus.data_b >> bus.shamt;
            OP_LUI:  result = {bus.data_b[HALF-1:0], {HALF{1'b0}}};
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}},
                               ($signed(bus.data_a) < $signed(bus.data_b))};
            OP_MFHI: result = hi_reg;
            OP_MFLO: result = lo_reg;
            default: result = '0;
        endcase
    end

    // Shift-add: partial = {accumulator, remaining multiplier bits}.
    assign mul_sum  = {1'b0, partial[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, operand};
    assign mul_next = partial[0] ? {mul_sum, partial[DATA_WIDTH-1:1]}
                                 : {1'b0, partial[2*DATA_WIDTH-1:1]};

    // Restoring divide: partial = {remainder, dividend/quotient}; b=0 yields all-ones quotient, remainder a.
    assign div_shift = partial[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign div_trial = div_shift - {1'b0, operand};
    assign div_next  = div_trial[DATA_WIDTH]
                     ? {div_shift[DATA_WIDTH-1:0], partial[DATA_WIDTH-2:0], 1'b0}
                     : {div_trial[DATA_WIDTH-1:0], partial[DATA_WIDTH-2:0], 1'b1};

    assign step_next = (state == MUL) ? mul_next : div_next;
    assign accept    = (state == IDLE) && bus.start &&
                       ((operation == OP_MULTU) || (operation == OP_DIVU));
    assign last_step = (state != IDLE) && (count == COUNT_WIDTH'(1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (operation == OP_MULTU) ? MUL : DIV;
            end
            MUL, DIV: begin
                if (last_step) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            operand  <= '0;
            partial  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                count   <= COUNT_WIDTH'(DATA_WIDTH);
                operand <= (operation == OP_MULTU) ? bus.data_a : bus.data_b;
                partial <= {{DATA_WIDTH{1'b0}},
                            (operation == OP_MULTU) ? bus.data_b : bus.data_a};
            end else if (state != IDLE) begin
                count   <= count - COUNT_WIDTH'(1);
                partial <= step_next;
                if (last_step) begin
                    hi_reg   <= step_next[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_reg   <= step_next[DATA_WIDTH-1:0];
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.alu_operation = operation;
    assign bus.alu_result    = result;
    assign bus.zero          = (result == '0);
    assign bus.illegal       = illegal;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_reg;
    assign bus.hi            = hi_reg;
    assign bus.lo            = lo_reg;
endmodule

`default_nettype wire
